event_counter_mc: RTL

Parametrised multi-channel event counter, the next generation of the single 8-bit counter with overflow.
- N_CH independent WIDTH-bit counters, each counting events on its own num_i bit.
- Each event is a rising edge or a high level of the bit, selected by parameter.
- Per channel: wrap or saturate mode at run time, synchronous clear, per-channel preload, sticky overflow flag and one-cycle overflow pulse.
- Sits beside the datapath as a statistics/event block. All inputs are synchronous to clk.

---
 rtl/event_counter_mc.sv | 83 ++++++++
 1 files changed

// File: rtl/event_counter_mc.sv
// Multi-channel event counter: per-channel wrap/saturate counting with preload,
// sticky overflow flag and a one-cycle overflow pulse.
module event_counter_mc #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = 1,
  parameter int CH_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         num_i,
  input  logic                    en_i,
  input  logic                    sat_i,
  input  logic                    clr_i,
  input  logic                    ld_i,
  input  logic [CH_W-1:0]         ld_ch_i,
  input  logic [WIDTH-1:0]        ld_val_i,
  output logic [N_CH*WIDTH-1:0]   cnt_o,
  output logic [N_CH-1:0]         of_o,
  output logic [N_CH-1:0]         of_pulse_o,
  output logic                    any_of_o
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] ev;

  // Edge history follows the input unconditionally so enabling mid-high never
  // fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= num_i;
  end

  assign ev = (EDGE_MODE != 0) ? (num_i & ~prev_q) : num_i;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

    logic [WIDTH-1:0] cnt_q;
    logic             of_q;
    logic             pulse_q;
    logic             ld_hit;

    // Out-of-range channel indices never match any CH_IDX, so they are ignored.
    assign ld_hit = ld_i && (ld_ch_i == CH_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        of_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else if (clr_i) begin
        cnt_q   <= '0;
        of_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else if (ld_hit) begin
        cnt_q   <= ld_val_i;
        of_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else if (en_i && ev[i]) begin
        if (cnt_q != MAX) begin
          cnt_q   <= cnt_q + 1'b1;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= sat_i ? MAX : '0;
          of_q    <= 1'b1;
          pulse_q <= 1'b1;
        end
      end else begin
        pulse_q <= 1'b0;
      end
    end

    assign cnt_o[i*WIDTH +: WIDTH] = cnt_q;
    assign of_o[i]                 = of_q;
    assign of_pulse_o[i]           = pulse_q;
  end

  assign any_of_o = |of_o;

endmodule
